// File: rtl/bus_arbiter.sv
// Four-master round-robin arbiter for the shared CPU memory bus.
// Optional starvation timeout is compiled in with `BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req_,
  output logic [3:0]   grnt_,
  input  logic [119:0] m_addr,
  input  logic [3:0]   m_as_,
  input  logic [3:0]   m_rw,
  input  logic [127:0] m_wr_data,
  output logic [29:0]  s_addr,
  output logic         s_as_,
  output logic         s_rw,
  output logic [31:0]  s_wr_data,
  output logic         arb_timeout
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  // Returns {found, index} of the first set bit after base, wrapping 3->0.
  function automatic logic [2:0] next_req(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    next_req = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (req[idx] && !next_req[2]) next_req = {1'b1, idx};
    end
  endfunction

  logic       state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q,  last_d;

  logic [3:0] req;
  logic [3:0] others;
  logic       owner_req;
  logic [2:0] pick_idle;
  logic [2:0] pick_rot;
  logic       timeout_hit;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       ato_q, ato_d;
  assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1)) && owner_req && (|others);
  assign arb_timeout = ato_q;
`else
  assign timeout_hit = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    req       = ~req_;
    owner_req = req[owner_q];
    others    = req & ~(4'b0001 << owner_q);
    pick_idle = next_req(req, last_q);
    pick_rot  = next_req(others, owner_q);

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_idle[2]) begin
          state_d = ST_GRANT;
          owner_d = pick_idle[1:0];
        end
      end
      default: begin
        // Release and timeout revocation hand over identically.
        if (!owner_req || timeout_hit) begin
          last_d = owner_q;
          if (pick_rot[2]) owner_d = pick_rot[1:0];
          else             state_d = ST_IDLE;
        end
      end
    endcase
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_comb begin
    ato_d = timeout_hit;
    if (state_q == ST_GRANT && state_d == ST_GRANT && owner_d == owner_q && (|others))
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = 8'd0;
  end
`endif

  always_comb begin
    grnt_     = 4'b1111;
    s_addr    = 30'd0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = 32'd0;
    if (state_q == ST_GRANT) begin
      grnt_[owner_q] = 1'b0;
      s_addr         = m_addr[30*int'(owner_q) +: 30];
      // A releasing owner must not strobe during its last cycle.
      s_as_          = m_as_[owner_q] | req_[owner_q];
      s_rw           = m_rw[owner_q];
      s_wr_data      = m_wr_data[32*int'(owner_q) +: 32];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
      ato_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ato_q <= ato_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: expected grants are queued before each
// edge and compared after it; bus mux values are checked against constants.
module tb_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_;
  logic [3:0]   grnt_;
  logic [119:0] m_addr;
  logic [3:0]   m_as_;
  logic [3:0]   m_rw;
  logic [127:0] m_wr_data;
  logic [29:0]  s_addr;
  logic         s_as_;
  logic         s_rw;
  logic [31:0]  s_wr_data;
  logic         arb_timeout;

  typedef struct packed {
    logic [3:0] grnt;
    logic       ato;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

`ifdef BUS_ARB_TIMEOUT_EN
  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
`else
  bus_arbiter dut (
`endif
    .clk(clk), .reset(reset), .req_(req_), .grnt_(grnt_),
    .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data),
    .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
    .arb_timeout(arb_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic a);
    exp_t x;
    x.grnt = g;
    x.ato  = a;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_ = 4'b1111; m_as_ = 4'b1111; m_rw = 4'b1111;
    m_addr = '0; m_wr_data = '0;
    for (int a = 0; a < 4; a++) begin
      m_addr[30*a +: 30]    = 30'h100 * (a + 1);
      m_wr_data[32*a +: 32] = 32'hA000_0000 + a;
    end
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (grnt_ !== 4'b1111) begin failures++; $display("FAIL reset_grnt got=%b exp=1111", grnt_); end
    checks++; if (s_as_ !== 1'b1) begin failures++; $display("FAIL reset_s_as got=%b exp=1", s_as_); end
    checks++; if (s_rw !== 1'b1) begin failures++; $display("FAIL reset_s_rw got=%b exp=1", s_rw); end
    checks++; if (s_addr !== 30'd0) begin failures++; $display("FAIL reset_s_addr got=%h exp=0", s_addr); end
    checks++; if (s_wr_data !== 32'd0) begin failures++; $display("FAIL reset_s_wr_data got=%h exp=0", s_wr_data); end
    checks++; if (arb_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", arb_timeout); end
  endtask

  task automatic test_grant_and_handover();
    req_ = 4'b1010;
    push(4'b1110, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL first_grant got=%b exp=%b", grnt_, e.grnt); end
    // Master 0 writes; master 2 strobes illegally and must be ignored.
    m_addr[29:0] = 30'h100; m_rw[0] = 1'b0; m_wr_data[31:0] = 32'hDEAD_BEEF; m_as_ = 4'b1010;
    #1;
    checks++; if (s_as_ !== 1'b0) begin failures++; $display("FAIL m0_s_as got=%b exp=0", s_as_); end
    checks++; if (s_addr !== 30'h100) begin failures++; $display("FAIL m0_s_addr got=%h exp=100", s_addr); end
    checks++; if (s_rw !== 1'b0) begin failures++; $display("FAIL m0_s_rw got=%b exp=0", s_rw); end
    checks++; if (s_wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL m0_s_wr_data got=%h exp=deadbeef", s_wr_data); end
    tick();
    // Master 0 releases with its strobe still low: bus strobe is suppressed.
    req_ = 4'b1011;
    #1;
    checks++; if (s_as_ !== 1'b1) begin failures++; $display("FAIL release_s_as got=%b exp=1", s_as_); end
    push(4'b1011, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL handover got=%b exp=%b", grnt_, e.grnt); end
    m_as_ = 4'b1111;
    #1;
    checks++; if (s_addr !== 30'h300) begin failures++; $display("FAIL m2_s_addr got=%h exp=300", s_addr); end
    checks++; if (s_rw !== 1'b1) begin failures++; $display("FAIL m2_s_rw got=%b exp=1", s_rw); end
    req_ = 4'b1111;
    push(4'b1111, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL m2_release got=%b exp=%b", grnt_, e.grnt); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; tick(); reset = 1'b0;
    req_ = 4'b0000;
    push(4'b1110, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL rr_start got=%b exp=%b", grnt_, e.grnt); end
    for (int k = 0; k < 4; k++) begin
      push(~(4'b0001 << k), 1'b0);
      tick();
      e = sb.pop_front();
      checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL rr_hold k=%0d got=%b exp=%b", k, grnt_, e.grnt); end
      req_[k] = 1'b1;
      push(~(4'b0001 << ((k + 1) % 4)), 1'b0);
      tick();
      e = sb.pop_front();
      checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL rr_next k=%0d got=%b exp=%b", k, grnt_, e.grnt); end
      req_[k] = 1'b0;
    end
    req_ = 4'b1111;
    push(4'b1111, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL rr_idle got=%b exp=%b", grnt_, e.grnt); end
  endtask

  task automatic test_single_master();
    req_ = 4'b0111;
    push(4'b0111, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL m3_grant got=%b exp=%b", grnt_, e.grnt); end
    m_as_ = 4'b0111; m_rw[3] = 1'b0;
    #1;
    checks++; if (s_wr_data !== 32'hA000_0003) begin failures++; $display("FAIL m3_s_wr_data got=%h exp=a0000003", s_wr_data); end
    checks++; if (s_addr !== 30'h400) begin failures++; $display("FAIL m3_s_addr got=%h exp=400", s_addr); end
    req_ = 4'b1111; m_as_ = 4'b1111;
    push(4'b1111, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL m3_idle got=%b exp=%b", grnt_, e.grnt); end
    checks++; if ({s_as_, s_rw, s_addr, s_wr_data} !== {1'b1, 1'b1, 30'd0, 32'd0}) begin
      failures++; $display("FAIL m3_idle_bus got=%b/%b/%h/%h exp=1/1/0/0", s_as_, s_rw, s_addr, s_wr_data);
    end
  endtask

  task automatic test_timeout();
    // last is 3 here, so master 1 beats master 2.
    req_ = 4'b1001;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) push(4'b1101, 1'b0);
    push(4'b1011, 1'b1);
    push(4'b1011, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      e = sb.pop_front();
      checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL to_grant c=%0d got=%b exp=%b", c, grnt_, e.grnt); end
      checks++; if (arb_timeout !== e.ato) begin failures++; $display("FAIL to_pulse c=%0d got=%b exp=%b", c, arb_timeout, e.ato); end
    end
`else
    for (int c = 0; c < 50; c++) push(4'b1101, 1'b0);
    for (int c = 0; c < 50; c++) begin
      tick();
      e = sb.pop_front();
      checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL hold_grant c=%0d got=%b exp=%b", c, grnt_, e.grnt); end
      checks++; if (arb_timeout !== e.ato) begin failures++; $display("FAIL hold_pulse c=%0d got=%b exp=%b", c, arb_timeout, e.ato); end
    end
`endif
    req_ = 4'b1111;
    tick(); tick();
    checks++; if (grnt_ !== 4'b1111) begin failures++; $display("FAIL to_idle got=%b exp=1111", grnt_); end
  endtask

  task automatic test_reset_mid_transfer();
    req_ = 4'b1101;
    push(4'b1101, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL mid_grant got=%b exp=%b", grnt_, e.grnt); end
    m_as_ = 4'b1101; m_rw[1] = 1'b0;
    #1;
    checks++; if (s_as_ !== 1'b0) begin failures++; $display("FAIL mid_strobe got=%b exp=0", s_as_); end
    reset = 1'b1;
    push(4'b1111, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL mid_reset_grnt got=%b exp=%b", grnt_, e.grnt); end
    checks++; if (s_as_ !== 1'b1) begin failures++; $display("FAIL mid_reset_s_as got=%b exp=1", s_as_); end
    reset = 1'b0; m_as_ = 4'b1111; req_ = 4'b0000;
    push(4'b1110, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (grnt_ !== e.grnt) begin failures++; $display("FAIL post_reset_grant got=%b exp=%b", grnt_, e.grnt); end
  endtask

  initial begin
    test_reset();
    test_grant_and_handover();
    test_round_robin();
    test_single_master();
    test_timeout();
    test_reset_mid_transfer();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
